// File: rtl/i2c_pkg.sv
// Shared state encodings, bus constants and default widths for the i2c
// register-read master, the slave block and their benches.
package i2c_pkg;

  localparam int unsigned DEV_AW_DEF = 7;
  localparam int unsigned REG_AW_DEF = 8;
  localparam int unsigned DATA_W_DEF = 8;

  localparam logic ACK      = 1'b0;
  localparam logic NACK     = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR_W,
    ST_ACK1,
    ST_REG,
    ST_ACK2,
    ST_GAP,
    ST_RSTART,
    ST_ADDR_R,
    ST_ACK3,
    ST_DATA,
    ST_MNACK,
    ST_STOP,
    ST_DONE
  } state_t;

endpackage

// File: rtl/i2c_bit_shifter.sv
// Loadable MSB-first shift register with a down-counting bit counter; serves
// both transmit (address/register) and receive (data) phases.
module i2c_bit_shifter #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         shift_i,
  input  logic         shift_in_i,
  output logic         msb_o,
  output logic [W-1:0] data_o,
  output logic         last_bit_o
);

  localparam int unsigned CW = $clog2(W);

  logic [W-1:0]  sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sr_d  = load_val_i;
      cnt_d = CW'(W - 1);
    end else if (shift_i) begin
      sr_d = {sr_q[W-2:0], shift_in_i};
      // Counter parks at zero; the owning phase exits on last_bit.
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign msb_o      = sr_q[W-1];
  assign data_o     = sr_q;
  assign last_bit_o = (cnt_q == '0);

endmodule

// File: rtl/i2c_master_rd.sv
// Single-wire register-read master: write address, register address, repeated
// start, read address, 8 data bits. Define I2C_MASTER_NACK_ABORT_EN to abort on NACK.
module i2c_master_rd
  import i2c_pkg::*;
#(
  parameter int unsigned DEV_AW     = DEV_AW_DEF,
  parameter int unsigned REG_AW     = REG_AW_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned RSTART_GAP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DEV_AW-1:0] dev_addr,
  input  logic [REG_AW-1:0] reg_addr,
  inout  wire               sda,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic              ack_err
);

  localparam int unsigned GAP_W = $clog2(RSTART_GAP + 1);

  state_t            state_q, state_d;
  logic [DEV_AW-1:0] dev_q, dev_d;
  logic [REG_AW-1:0] reg_q, reg_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              nack_q, nack_d;
  logic              ack_err_q, ack_err_d;
  logic [GAP_W-1:0]  gap_q, gap_d;

  logic              sh_load, sh_shift, sh_msb, sh_last;
  logic [DATA_W-1:0] sh_load_val, sh_data;
  logic              sda_en, sda_drv, sda_ack;

  assign sda     = sda_en ? sda_drv : 1'bz;
  assign sda_ack = (sda === ACK);

  i2c_bit_shifter #(.W(DATA_W)) u_shift (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (sh_load),
    .load_val_i (sh_load_val),
    .shift_i    (sh_shift),
    .shift_in_i (sda),
    .msb_o      (sh_msb),
    .data_o     (sh_data),
    .last_bit_o (sh_last)
  );

  always_comb begin
    state_d     = state_q;
    dev_d       = dev_q;
    reg_d       = reg_q;
    rd_data_d   = rd_data_q;
    nack_d      = nack_q;
    ack_err_d   = ack_err_q;
    gap_d       = '0;
    sh_load     = 1'b0;
    sh_load_val = '0;
    sh_shift    = 1'b0;
    sda_en      = 1'b0;
    sda_drv     = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_START;
          dev_d     = dev_addr;
          reg_d     = reg_addr;
          nack_d    = 1'b0;
          ack_err_d = 1'b0;
        end
      end
      ST_START: begin
        sda_en      = 1'b1;
        sda_drv     = 1'b0;
        sh_load     = 1'b1;
        sh_load_val = {dev_q, RW_WRITE};
        state_d     = ST_ADDR_W;
      end
      ST_ADDR_W: begin
        sda_en   = 1'b1;
        sda_drv  = sh_msb;
        sh_shift = 1'b1;
        if (sh_last) state_d = ST_ACK1;
      end
      ST_ACK1: begin
        sh_load     = 1'b1;
        sh_load_val = reg_q;
        state_d     = ST_REG;
        if (!sda_ack) begin
          nack_d = 1'b1;
`ifdef I2C_MASTER_NACK_ABORT_EN
          state_d = ST_STOP;
`endif
        end
      end
      ST_REG: begin
        sda_en   = 1'b1;
        sda_drv  = sh_msb;
        sh_shift = 1'b1;
        if (sh_last) state_d = ST_ACK2;
      end
      ST_ACK2: begin
        state_d = ST_GAP;
        if (!sda_ack) begin
          nack_d = 1'b1;
`ifdef I2C_MASTER_NACK_ABORT_EN
          state_d = ST_STOP;
`endif
        end
      end
      ST_GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_W'(RSTART_GAP - 1)) begin
          gap_d   = '0;
          state_d = ST_RSTART;
        end
      end
      ST_RSTART: begin
        sda_en      = 1'b1;
        sda_drv     = 1'b0;
        sh_load     = 1'b1;
        sh_load_val = {dev_q, RW_READ};
        state_d     = ST_ADDR_R;
      end
      ST_ADDR_R: begin
        sda_en   = 1'b1;
        sda_drv  = sh_msb;
        sh_shift = 1'b1;
        if (sh_last) state_d = ST_ACK3;
      end
      ST_ACK3: begin
        sh_load = 1'b1;
        state_d = ST_DATA;
        if (!sda_ack) begin
          nack_d = 1'b1;
`ifdef I2C_MASTER_NACK_ABORT_EN
          state_d = ST_STOP;
`endif
        end
      end
      ST_DATA: begin
        sh_shift = 1'b1;
        if (sh_last) state_d = ST_MNACK;
      end
      ST_MNACK: begin
        sda_en  = 1'b1;
        sda_drv = NACK;
        state_d = ST_STOP;
      end
      ST_STOP: begin
        state_d   = ST_DONE;
        ack_err_d = nack_q;
        // The shifter holds the received byte from the end of DATA until the next load.
`ifdef I2C_MASTER_NACK_ABORT_EN
        if (!nack_q) rd_data_d = sh_data;
`else
        rd_data_d = sh_data;
`endif
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      dev_q     <= '0;
      reg_q     <= '0;
      rd_data_q <= '0;
      nack_q    <= 1'b0;
      ack_err_q <= 1'b0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      dev_q     <= dev_d;
      reg_q     <= reg_d;
      rd_data_q <= rd_data_d;
      nack_q    <= nack_d;
      ack_err_q <= ack_err_d;
      gap_q     <= gap_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign rd_data = rd_data_q;
  assign ack_err = ack_err_q;

endmodule

// File: tb/tb_i2c_master_rd.sv
// Directed bench for i2c_master_rd with an addressable register-read slave
// model on a pulled-up shared sda line.
module tb_i2c_master_rd;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [6:0] dev_addr = '0;
  logic [7:0] reg_addr = '0;
  logic       busy, done, ack_err;
  logic [7:0] rd_data;
  wire        sda;

  logic        s_en = 1'b0;
  logic        s_drv = 1'b1;
  logic        s_match = 1'b0;
  logic [6:0]  s_dev = '0;
  logic [7:0]  s_reg = '0;
  logic [7:0]  s_val = '0;
  int unsigned k = 0;

  int unsigned total = 0;
  int unsigned bad = 0;

  localparam logic [6:0]  SLV_ADDR = 7'h2A;
  localparam logic [39:0] EXP_NOM = {1'b0, 7'h2A, 1'b0, 1'b0, 8'hBE, 1'b0, 1'b1,
                                     1'b0, 7'h2A, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b1};

  assign sda = s_en ? s_drv : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_master_rd #(.DEV_AW(7), .REG_AW(8), .DATA_W(8), .RSTART_GAP(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dev_addr (dev_addr),
    .reg_addr (reg_addr),
    .sda      (sda),
    .busy     (busy),
    .done     (done),
    .rd_data  (rd_data),
    .ack_err  (ack_err)
  );

  function automatic logic [7:0] reg_val(input logic [7:0] r);
    case (r)
      8'hBE:   return 8'h5A;
      8'h10:   return 8'hA5;
      default: return ~r;
    endcase
  endfunction

  // Slave model: k is the index of the current transaction cycle (1 = START).
  always @(posedge clk) begin
    if (k >= 2 && k <= 8) s_dev = {s_dev[5:0], sda};
    if (k >= 11 && k <= 18) s_reg = {s_reg[6:0], sda};
    #1;
    k = busy ? k + 1 : 0;
    if (k == 1) s_match = 1'b0;
    if (k == 10) s_match = (s_dev == SLV_ADDR);
    if (k == 31) s_val = reg_val(s_reg);
    s_en  = 1'b0;
    s_drv = 1'b1;
    if (s_match && (k == 10 || k == 19 || k == 30)) begin
      s_en  = 1'b1;
      s_drv = 1'b0;
    end
    if (s_match && k >= 31 && k <= 38) begin
      s_en  = 1'b1;
      s_drv = s_val[38 - k];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [6:0] d, input logic [7:0] r);
    dev_addr = d;
    reg_addr = r;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Called at the negedge of cycle 1; returns at the negedge of cycle done+linger.
  task automatic monitor(input int unsigned pulse_at, input int unsigned linger,
                         output logic [39:0] tr, output int unsigned done_at,
                         output int unsigned done_cnt);
    tr       = '0;
    done_at  = 0;
    done_cnt = 0;
    for (int unsigned c = 1; c <= 60; c++) begin
      if (c <= 40) tr = {tr[38:0], sda};
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at == 0) done_at = c;
      end
      start = (c == pulse_at);
      if (c == pulse_at) begin
        dev_addr = 7'h55;
        reg_addr = 8'h33;
      end
      if (done_at != 0 && c >= done_at + linger) break;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    logic [39:0] tr;
    int unsigned done_at, done_cnt, dcount;
    int unsigned exp_nack_done;
    logic [7:0]  exp_nack_rd;
`ifdef I2C_MASTER_NACK_ABORT_EN
    exp_nack_done = 12;
    exp_nack_rd   = 8'h5A;
`else
    exp_nack_done = 41;
    exp_nack_rd   = 8'hFF;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_ack_err", ack_err, 1'b0);
    check("rst_sda_released", sda, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    // Nominal read of 0xBE on device 0x2A
    launch(7'h2A, 8'hBE);
    check("nom_busy_start", busy, 1'b1);
    monitor(0, 1, tr, done_at, done_cnt);
    check("nom_trace", tr, EXP_NOM);
    check("nom_done_at", done_at, 41);
    check("nom_done_cnt", done_cnt, 1);
    check("nom_busy_after", busy, 1'b0);
    check("nom_rd_data", rd_data, 8'h5A);
    check("nom_ack_err", ack_err, 1'b0);

    // start pulsed mid-transaction with different addresses is ignored
    launch(7'h2A, 8'hBE);
    monitor(10, 4, tr, done_at, done_cnt);
    check("busy_start_trace", tr, EXP_NOM);
    check("busy_start_done_at", done_at, 41);
    check("busy_start_done_cnt", done_cnt, 1);
    check("busy_start_rd_data", rd_data, 8'h5A);

    // Device NACK: nobody answers address 0x11
    launch(7'h11, 8'hBE);
    monitor(0, 1, tr, done_at, done_cnt);
    check("nack_done_at", done_at, exp_nack_done);
    check("nack_ack_err", ack_err, 1'b1);
    check("nack_rd_data", rd_data, exp_nack_rd);

    // Back-to-back: start in the idle cycle right after done, read reg 0x10
    launch(7'h2A, 8'h10);
    check("b2b_busy", busy, 1'b1);
    check("b2b_ack_err_cleared", ack_err, 1'b0);
    check("b2b_rd_data_held", rd_data, exp_nack_rd);
    monitor(0, 1, tr, done_at, done_cnt);
    check("b2b_done_at", done_at, 41);
    check("b2b_rd_data", rd_data, 8'hA5);
    check("b2b_ack_err", ack_err, 1'b0);

    // Reset at cycle 20 with a coincident start
    launch(7'h2A, 8'hBE);
    repeat (19) @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_sda", sda, 1'b1);
    check("mid_rst_rd_data", rd_data, 8'h00);
    check("mid_rst_ack_err", ack_err, 1'b0);
    rst   = 1'b0;
    start = 1'b0;
    dcount = 0;
    for (int i = 0; i < 45; i++) begin
      if (done === 1'b1) dcount++;
      @(negedge clk);
    end
    check("mid_rst_no_done", dcount, 0);
    launch(7'h2A, 8'hBE);
    monitor(0, 1, tr, done_at, done_cnt);
    check("post_rst_trace", tr, EXP_NOM);
    check("post_rst_done_at", done_at, 41);
    check("post_rst_rd_data", rd_data, 8'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
